// File: rtl/pipe_stage_reg_if.sv
`timescale 1ns/1ps
// Valid/ready/data channel between pipeline stages.
// master drives valid+data and samples ready; slave does the opposite.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
// Generic pipeline stage register: valid/ready handshake, optional 2-entry
// skid buffer (registered in_ready), flush-to-bubble and a saturating stall
// counter. The main register doubles as the out_data register, so the output
// is BUBBLE whenever the stage is empty.
module pipe_stage_reg #(
   parameter int                DATA_W = 32,
   parameter bit                SKID   = 1'b1,
   parameter logic [DATA_W-1:0] BUBBLE = 'h13,
   parameter int                CNT_W  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    flush_i,
   pipe_stage_reg_if.slave         in_if,
   pipe_stage_reg_if.master        out_if,
   input  logic                    stall_clr_i,
   output logic [CNT_W-1:0]        stall_cnt_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid;
   logic              in_ready;
   logic              acc, pop;

   assign acc = in_if.valid & in_ready;
   assign pop = out_valid & out_if.ready;

   // State and main/output payload; main resets to BUBBLE so out_data is clean out of reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_EMPTY;
         main_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   // Skid payload needs no reset: its validity lives entirely in state_q
   always_ff @(posedge clk_i) begin
      skid_q <= skid_d;
   end

   // Next-state/payload: main is always the oldest entry, skid the next one
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (acc) begin
               state_d = S_FULL;
               main_d  = in_if.data;
            end
         end
         S_FULL: begin
            if (acc && pop) begin
               main_d = in_if.data;
            end else if (acc && SKID) begin
               // without a skid, in_ready==out_ready in FULL, so acc implies pop
               state_d = S_SKID;
               skid_d  = in_if.data;
            end else if (pop) begin
               state_d = S_EMPTY;
               main_d  = BUBBLE;
            end
         end
         S_SKID: begin
            if (pop) begin
               state_d = S_FULL;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = S_EMPTY;
            main_d  = BUBBLE;
         end
      endcase
      // flush wins over everything, dropping any same-cycle accept
      if (flush_i) begin
         state_d = S_EMPTY;
         main_d  = BUBBLE;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic in_ready_q;
         // Registered in_ready: low only while both entries are occupied
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) in_ready_q <= 1'b1;
            else          in_ready_q <= (state_d != S_SKID);
         end
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign in_ready = !out_valid | out_if.ready;
      end
   endgenerate

   // Outputs decoded from registered state
   always_comb begin
      out_valid    = (state_q != S_EMPTY);
      out_if.valid = out_valid;
      out_if.data  = main_q;
      in_if.ready  = in_ready;
   end

   // Stall counter next value: clear beats increment, saturates at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (stall_clr_i)
         cnt_d = '0;
      else if (out_valid && !out_if.ready && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Stall counter register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign stall_cnt_o = cnt_q;

endmodule
